datamemory_ctrl: RTL

- Parametrised, handshaked successor to the single-cycle data memory, sitting between the EX/MEM stage and the data RAM.
- Supports the full RV32I load/store set: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Byte-enabled stores, with sign/zero-extended loads.
- Configurable access latency (wait states) and detection of misaligned or illegal accesses.
- Storage is internal: a word array of 2**(DM_ADDRESS-2) entries.

---
 rtl/dm_pkg.sv | 33 +++
 rtl/dm_lane_align.sv | 58 +++++
 rtl/datamemory_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory controller: Funct3 codes, FSM states
// and the request legality rule.
package dm_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dm_state_t;

   // op is {MemWrite, MemRead}; exactly one must be set.
   function automatic logic is_legal(input logic [1:0] op, input logic [2:0] f3,
                                     input logic [1:0] a_lo);
      logic ok;
      ok = 1'b0;
      case (op)
         2'b01:   ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
         2'b10:   ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
         default: ok = 1'b0;
      endcase
      ok = ok && !((f3[1:0] == 2'b01) && a_lo[0])
              && !((f3[1:0] == 2'b10) && (a_lo != 2'b00));
      return ok;
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering between the 32-bit RAM word and the core: store enables and
// data replication, load lane extraction with sign/zero extension.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [2:0]  f3,
   input  logic [1:0]  a_lo,
   input  logic [31:0] wd,
   input  logic [31:0] word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign byte_s = word[{a_lo, 3'b000} +: 8];
   assign half_s = a_lo[1] ? word[31:16] : word[15:0];

   // Store side: lanes selected by size and low address bits.
   always_comb begin
      be    = 4'b0000;
      wdata = wd;
      case (f3[1:0])
         2'b00: begin
            be    = 4'b0001 << a_lo;
            wdata = {4{wd[7:0]}};
         end
         2'b01: begin
            be    = a_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{wd[15:0]}};
         end
         2'b10: begin
            be    = 4'b1111;
            wdata = wd;
         end
         default: begin
            be    = 4'b0000;
            wdata = wd;
         end
      endcase
   end

   // Load side: extract the addressed lane and extend it.
   always_comb begin
      ld = word;
      case (f3)
         F3_B:    ld = {{24{byte_s[7]}}, byte_s};
         F3_BU:   ld = {24'h000000, byte_s};
         F3_H:    ld = {{16{half_s[15]}}, half_s};
         F3_HU:   ld = {16'h0000, half_s};
         F3_W:    ld = word;
         default: ld = word;
      endcase
   end

endmodule

// File: rtl/datamemory_ctrl.sv
// Handshaked RV32I data memory: one request at a time, configurable wait states,
// fault response for misaligned or malformed requests.
module datamemory_ctrl
   import dm_pkg::*;
#(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] a,
   input  logic [DATA_W-1:0]     wd,
   input  logic [2:0]            Funct3,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rd,
   output logic                  fault
);

   localparam int DEPTH = 2 ** (DM_ADDRESS - 2);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("datamemory_ctrl: DATA_W must be 32");
   end
   if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait
      $error("datamemory_ctrl: WAIT_STATES must be 0..15");
   end

   dm_state_t             state_r;
   logic [3:0]            cnt_r;
   logic [DM_ADDRESS-1:0] a_r;
   logic [31:0]           wd_r;
   logic [2:0]            f3_r;
   logic                  wr_r;
   logic                  fault_pend_r;
   logic                  req_ready_r;
   logic                  rsp_valid_r;
   logic                  fault_r;
   logic [31:0]           rd_r;
   logic [31:0]           mem_r [DEPTH];
   logic [31:0]           word_s;
   logic [31:0]           wdata_s;
   logic [31:0]           ld_s;
   logic [3:0]            be_s;
   logic                  access_s;
   logic                  mem_we_s;

   assign word_s    = mem_r[a_r[DM_ADDRESS-1:2]];
   assign access_s  = (state_r == BUSY) && (cnt_r == 4'd0) && !fault_pend_r;
   assign mem_we_s  = access_s && wr_r;
   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign fault     = fault_r;
   assign rd        = rd_r;

   dm_lane_align u_align (
      .f3    (f3_r),
      .a_lo  (a_r[1:0]),
      .wd    (wd_r),
      .word  (word_s),
      .be    (be_s),
      .wdata (wdata_s),
      .ld    (ld_s)
   );

   // Byte-enabled RAM write; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_r[a_r[DM_ADDRESS-1:2]][8*i +: 8] <= wdata_s[8*i +: 8];
            end
         end
      end
   end

   // Request FSM; faulted requests take the zero-wait path with the access suppressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         a_r          <= '0;
         wd_r         <= 32'h0000_0000;
         f3_r         <= 3'b000;
         wr_r         <= 1'b0;
         fault_pend_r <= 1'b0;
         req_ready_r  <= 1'b1;
         rsp_valid_r  <= 1'b0;
         fault_r      <= 1'b0;
         rd_r         <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  a_r         <= a;
                  wd_r        <= wd;
                  f3_r        <= Funct3;
                  wr_r        <= MemWrite;
                  req_ready_r <= 1'b0;
                  state_r     <= BUSY;
                  if (is_legal({MemWrite, MemRead}, Funct3, a[1:0])) begin
                     cnt_r        <= 4'(WAIT_STATES);
                     fault_pend_r <= 1'b0;
                  end else begin
                     cnt_r        <= 4'd0;
                     fault_pend_r <= 1'b1;
                  end
               end
            end
            BUSY: begin
               if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  if (access_s && !wr_r) begin
                     rd_r <= ld_s;
                  end
                  fault_r     <= fault_pend_r;
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
               end
            end
            RESP: begin
               rsp_valid_r  <= 1'b0;
               fault_r      <= 1'b0;
               fault_pend_r <= 1'b0;
               req_ready_r  <= 1'b1;
               state_r      <= IDLE;
            end
            default: begin
               rsp_valid_r  <= 1'b0;
               fault_r      <= 1'b0;
               fault_pend_r <= 1'b0;
               req_ready_r  <= 1'b1;
               state_r      <= IDLE;
            end
         endcase
      end
   end

endmodule
